// File: rtl/crack_pkg.sv
// Shared types and constants for the ARC4 key-search controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents: FSM state encoding, printable-ASCII bounds, printability helper.
package crack_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    ARM    = 3'd2,
    RUN    = 3'd3,
    CHECK  = 3'd4
  } crack_state_t;

  localparam logic [7:0] PRINT_LO = 8'h20;
  localparam logic [7:0] PRINT_HI = 8'h7E;

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= PRINT_LO) && (b <= PRINT_HI);
  endfunction

endpackage

// File: rtl/crack_sched_pt_filter.sv
// Plaintext snoop filter: flags a candidate as bad on any non-printable message byte.
// Latency: a write seen in cycle n is reflected in bad from cycle n+1.
// Backpressure: none; purely observes the arc4 write port, never stalls it.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   clr               synchronous clear of bad (wins over a same-cycle hit)
//   snoop             qualify the write port; writes outside a run are ignored
//   wren/addr/wrdata  snooped arc4 plaintext write port
//   bad               sticky flag, set by a non-printable byte at address >= 1
module pt_filter
  import crack_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       snoop,
  input  logic       wren,
  input  logic [7:0] addr,
  input  logic [7:0] wrdata,
  output logic       bad
);

  logic hit;

  // Address 0 holds the message length, which is binary and never checked.
  assign hit = snoop && wren && (addr != 8'h00) && !is_printable(wrdata);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bad <= 1'b0;
    end else if (clr) begin
      bad <= 1'b0;
    end else if (hit) begin
      bad <= 1'b1;
    end
  end

endmodule

// File: rtl/crack_sched.sv
// Key-search controller: runs one arc4 core per candidate key until a printable plaintext is seen.
// Latency: en to first a4_en >= 1 cycle; per candidate 3 cycles (LAUNCH, ARM, CHECK) plus the arc4 run.
// Backpressure: waits in LAUNCH for a4_rdy; en accepted only while rdy; stop honoured after the current run.
//
// Ports:
//   clk, rst                       clock, async active-high reset
//   en / rdy                       start handshake with top-level control (rdy high only in IDLE)
//   stop                           early-termination request, latched while searching
//   key / key_valid                result of the last search, held until the next accepted en
//   a4_en / a4_rdy / a4_key        arc4 start pulse, arc4 ready, candidate key (stable during a run)
//   a4_pt_wren/addr/wrdata         snooped arc4 plaintext write port
module crack_sched
  import crack_pkg::*;
#(
  parameter int              KEY_W     = 24,
  parameter logic [KEY_W-1:0] KEY_FIRST = '0,
  parameter logic [KEY_W-1:0] KEY_LAST  = '1,
  parameter int              KEY_STEP  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             rdy,
  input  logic             stop,
  output logic [KEY_W-1:0] key,
  output logic             key_valid,
  output logic             a4_en,
  input  logic             a4_rdy,
  output logic [KEY_W-1:0] a4_key,
  input  logic             a4_pt_wren,
  input  logic [7:0]       a4_pt_addr,
  input  logic [7:0]       a4_pt_wrdata
);

  localparam logic [KEY_W-1:0] STEP = KEY_W'(KEY_STEP);

  crack_state_t state, state_nxt;

  logic bad;
  logic stop_q;
  logic stop_any;
  logic exhausted;

  // Decoded actions from the output process.
  logic bad_clr;
  logic snoop;
  logic start_acc;
  logic found;
  logic advance;

  // A stop arriving in the CHECK cycle itself is honoured as well as a latched one.
  assign stop_any = stop_q | stop;

  // Distance to the last key, unsigned at KEY_W bits; a4_key never passes KEY_LAST,
  // so this cannot underflow and the key cannot wrap.
  assign exhausted = (KEY_LAST - a4_key) < STEP;

  pt_filter u_pt_filter (
    .clk    (clk),
    .rst    (rst),
    .clr    (bad_clr),
    .snoop  (snoop),
    .wren   (a4_pt_wren),
    .addr   (a4_pt_addr),
    .wrdata (a4_pt_wrdata),
    .bad    (bad)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (en) state_nxt = LAUNCH;
      LAUNCH:  if (a4_rdy) state_nxt = ARM;
      // The core may still report ready the cycle after a4_en, so ARM never samples it.
      ARM:     state_nxt = RUN;
      RUN:     if (a4_rdy) state_nxt = CHECK;
      CHECK: begin
        if (!bad || stop_any || exhausted) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = LAUNCH;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output / action decode.
  always_comb begin
    rdy       = 1'b0;
    a4_en     = 1'b0;
    bad_clr   = 1'b0;
    snoop     = 1'b0;
    start_acc = 1'b0;
    found     = 1'b0;
    advance   = 1'b0;
    unique case (state)
      IDLE: begin
        rdy       = 1'b1;
        start_acc = en;
      end
      LAUNCH: begin
        a4_en   = a4_rdy;
        bad_clr = 1'b1;
      end
      ARM, RUN: begin
        snoop = 1'b1;
      end
      CHECK: begin
        // A found key takes priority over stop and exhaustion.
        found   = !bad;
        advance = bad && !stop_any && !exhausted;
      end
      default: ;
    endcase
  end

  // Datapath: candidate key, result, latched stop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a4_key    <= KEY_FIRST;
      key       <= '0;
      key_valid <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      if (start_acc) begin
        a4_key    <= KEY_FIRST;
        key_valid <= 1'b0;
        stop_q    <= 1'b0;
      end else begin
        if (stop) begin
          stop_q <= 1'b1;
        end
        if (advance) begin
          a4_key <= a4_key + STEP;
        end
        if (found) begin
          key       <= a4_key;
          key_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crack_sched.sv
// Self-checking bench for crack_sched: three instances with different key ranges, each driven by
// a behavioural arc4 model whose plaintext is printable only for a chosen key.
// Expected launch sequences and results come from a per-instance search model built from the rules.
module tb_crack_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst;
  logic [2:0]  en;
  logic [2:0]  stop;
  logic [2:0]  rdy_v;
  logic [2:0]  kv_v;
  logic [2:0]  aen_v;
  logic [2:0]  ardy_v;
  logic [23:0] key_v    [3];
  logic [23:0] akey_v   [3];
  logic [23:0] pass_key [3];
  int          mode     [3];

  // Search model state.
  logic [23:0] exp_q [3][$];
  int          n_launch  [3];
  logic        exp_found [3];
  logic [23:0] exp_key   [3];

  int n_vec = 0;
  int n_err = 0;

  // arc4 write script: mode 0 = length 4 then 4 bytes, last byte printable only for the pass key
  // (0x7F / 0x1F straddle the printable range); mode 1 = two writes to address 0 only.
  function automatic int nwr(input int m);
    return (m == 1) ? 2 : 5;
  endfunction

  function automatic logic [15:0] wr(input int m, input logic [23:0] k, input logic [23:0] p, input int i);
    logic [15:0] r;
    if (m == 1) begin
      r = (i == 0) ? 16'h0000 : 16'h000A;
    end else begin
      case (i)
        0:       r = 16'h0004;
        1:       r = 16'h0120;
        2:       r = 16'h027E;
        3:       r = 16'h0341;
        default: r = (k == p) ? 16'h047E : (k[0] ? 16'h047F : 16'h041F);
      endcase
    end
    return r;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [23:0] FIRST = (g == 0) ? 24'h000000 : (g == 1) ? 24'hFFFFFC : 24'h000001;
    localparam logic [23:0] LAST  = (g == 2) ? 24'h000009 : 24'hFFFFFF;
    localparam int          STEP  = (g == 2) ? 2 : 1;

    logic [1:0]  ph;   // 0 idle, 1 lag (still ready), 2 busy, 3 last write with ready
    int          idx;
    int          cur;
    logic [23:0] ck;
    logic        wren;
    logic [7:0]  addr;
    logic [7:0]  wdata;

    crack_sched #(
      .KEY_W     (24),
      .KEY_FIRST (FIRST),
      .KEY_LAST  (LAST),
      .KEY_STEP  (STEP)
    ) u_dut (
      .clk          (clk),
      .rst          (rst[g]),
      .en           (en[g]),
      .rdy          (rdy_v[g]),
      .stop         (stop[g]),
      .key          (key_v[g]),
      .key_valid    (kv_v[g]),
      .a4_en        (aen_v[g]),
      .a4_rdy       (ardy_v[g]),
      .a4_key       (akey_v[g]),
      .a4_pt_wren   (wren),
      .a4_pt_addr   (addr),
      .a4_pt_wrdata (wdata)
    );

    assign ardy_v[g] = (ph != 2'd2);
    assign cur       = (ph == 2'd1) ? 0 : idx;

    always @(posedge clk or posedge rst[g]) begin
      if (rst[g]) begin
        ph    <= 2'd0;
        idx   <= 0;
        ck    <= '0;
        wren  <= 1'b0;
        addr  <= '0;
        wdata <= '0;
      end else begin
        wren <= 1'b0;
        case (ph)
          2'd0: if (aen_v[g]) begin
            ph <= 2'd1;
            ck <= akey_v[g];
          end
          2'd1, 2'd2: begin
            {addr, wdata} <= wr(mode[g], ck, pass_key[g], cur);
            wren          <= 1'b1;
            idx           <= cur + 1;
            ph            <= (cur == nwr(mode[g]) - 1) ? 2'd3 : 2'd2;
          end
          default: ph <= 2'd0;
        endcase
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Advance to the next falling edge and check every launch and the busy-time result flag.
  task automatic tick();
    @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      if (aen_v[g] === 1'b1) begin
        n_vec++;
        if (n_launch[g] >= exp_q[g].size()) begin
          n_err++;
          $display("FAIL launch_extra[%0d]: a4_key=%h launched, expected no launch", g, akey_v[g]);
        end else if (akey_v[g] !== exp_q[g][n_launch[g]]) begin
          n_err++;
          $display("FAIL launch_key[%0d]#%0d: got %h expected %h", g, n_launch[g], akey_v[g],
                   exp_q[g][n_launch[g]]);
        end
        n_launch[g]++;
      end
      if (rdy_v[g] === 1'b0) begin
        n_vec++;
        if (kv_v[g] !== 1'b0) begin
          n_err++;
          $display("FAIL kv_busy[%0d]: got %b expected 0", g, kv_v[g]);
        end
      end
    end
  endtask

  // Expected keys tried, in order, and the outcome of one search.
  task automatic build(input int g, input longint first, input longint last, input longint step,
                       input logic [23:0] p, input int m, input int stop_after);
    longint k;
    k            = first;
    pass_key[g]  = p;
    mode[g]      = m;
    exp_found[g] = 1'b0;
    exp_key[g]   = '0;
    n_launch[g]  = 0;
    exp_q[g].delete();
    for (int n = 0; n < 64; n++) begin
      exp_q[g].push_back(k[23:0]);
      if (m == 1 || k == longint'(p)) begin
        exp_found[g] = 1'b1;
        exp_key[g]   = k[23:0];
        break;
      end
      if (stop_after != 0 && exp_q[g].size() >= stop_after) break;
      if (last - k < step) break;
      k += step;
    end
  endtask

  task automatic run(input int g, input int stop_at, input bit poke_en);
    bit done;
    bit stopped;
    en[g] = 1'b1;
    tick();
    en[g] = 1'b0;
    chk($sformatf("rdy_after_en[%0d]", g), 32'(rdy_v[g]), 32'd0);
    chk($sformatf("a4_en_first[%0d]", g), 32'(aen_v[g]), 32'd1);
    done    = 1'b0;
    stopped = 1'b0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      if (stop_at != 0 && !stopped && n_launch[g] == stop_at && ardy_v[g] == 1'b0) begin
        stop[g] = 1'b1;
        stopped = 1'b1;
      end
      if (poke_en && cyc == 6) en[g] = 1'b1;
      tick();
      stop[g] = 1'b0;
      en[g]   = 1'b0;
      if (rdy_v[g] === 1'b1) done = 1'b1;
    end
    chk($sformatf("search_done[%0d]", g), 32'(done), 32'd1);
    chk($sformatf("launches[%0d]", g), 32'(n_launch[g]), 32'(exp_q[g].size()));
    chk($sformatf("key_valid[%0d]", g), 32'(kv_v[g]), 32'(exp_found[g]));
    if (exp_found[g]) chk($sformatf("key[%0d]", g), 32'(key_v[g]), 32'(exp_key[g]));
  endtask

  initial begin
    bit reached;
    logic [23:0] firsts [3];
    firsts[0] = 24'h000000;
    firsts[1] = 24'hFFFFFC;
    firsts[2] = 24'h000001;
    rst  = 3'b111;
    en   = 3'b000;
    stop = 3'b000;
    for (int g = 0; g < 3; g++) begin
      pass_key[g]  = '0;
      mode[g]      = 0;
      n_launch[g]  = 0;
      exp_found[g] = 1'b0;
      exp_key[g]   = '0;
    end
    repeat (3) @(negedge clk);
    rst = 3'b000;
    tick();

    for (int g = 0; g < 3; g++) begin
      chk($sformatf("rst_rdy[%0d]", g), 32'(rdy_v[g]), 32'd1);
      chk($sformatf("rst_kv[%0d]", g), 32'(kv_v[g]), 32'd0);
      chk($sformatf("rst_key[%0d]", g), 32'(key_v[g]), 32'd0);
      chk($sformatf("rst_a4_key[%0d]", g), 32'(akey_v[g]), 32'(firsts[g]));
      chk($sformatf("rst_a4_en[%0d]", g), 32'(aen_v[g]), 32'd0);
    end

    // Only key 3 passes; an en poke mid-search must be ignored.
    build(0, 0, 24'hFFFFFF, 1, 24'h000003, 0, 0);
    run(0, 0, 1'b1);
    chk("A_launches", 32'(n_launch[0]), 32'd4);
    chk("A_key", 32'(key_v[0]), 32'h000003);
    chk("A_kv", 32'(kv_v[0]), 32'd1);
    chk("A_rdy", 32'(rdy_v[0]), 32'd1);

    // Top of the key space, nothing passes: FC..FF tried, no wrap to 0 (which would pass).
    build(1, 24'hFFFFFC, 24'hFFFFFF, 1, 24'h000000, 0, 0);
    run(1, 0, 1'b1);
    chk("B_launches", 32'(n_launch[1]), 32'd4);
    chk("B_no_wrap", 32'(akey_v[1]), 32'h00FFFFFF);
    chk("B_kv", 32'(kv_v[1]), 32'd0);

    // Step 2 from key 1: the passing key 4 is never driven.
    build(2, 1, 24'h000009, 2, 24'h000004, 0, 0);
    run(2, 0, 1'b1);
    chk("C_launches", 32'(n_launch[2]), 32'd5);
    chk("C_last_key", 32'(akey_v[2]), 32'h000009);
    chk("C_kv", 32'(kv_v[2]), 32'd0);

    // Stop during the second run: that run completes, no third launch.
    build(0, 0, 24'hFFFFFF, 1, 24'hFFFFFF, 0, 2);
    run(0, 2, 1'b0);
    repeat (20) tick();
    chk("D_launches", 32'(n_launch[0]), 32'd2);
    chk("D_kv", 32'(kv_v[0]), 32'd0);
    chk("D_rdy", 32'(rdy_v[0]), 32'd1);

    // Stop while idle is harmless; writes to address 0 only are never checked.
    stop[0] = 1'b1;
    tick();
    stop[0] = 1'b0;
    tick();
    build(0, 0, 24'hFFFFFF, 1, 24'hFFFFFF, 1, 0);
    run(0, 0, 1'b0);
    chk("E_launches", 32'(n_launch[0]), 32'd1);
    chk("E_key", 32'(key_v[0]), 32'd0);
    chk("E_kv", 32'(kv_v[0]), 32'd1);

    // Asynchronous reset during the second run, then a full restart from KEY_FIRST.
    build(0, 0, 24'hFFFFFF, 1, 24'h000002, 0, 0);
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    reached = 1'b0;
    for (int cyc = 0; cyc < 200 && !reached; cyc++) begin
      tick();
      if (n_launch[0] == 2 && ardy_v[0] == 1'b0) reached = 1'b1;
    end
    chk("F_reached_run", 32'(reached), 32'd1);
    #3 rst[0] = 1'b1;
    #1;
    chk("F_rst_a4_en", 32'(aen_v[0]), 32'd0);
    chk("F_rst_rdy", 32'(rdy_v[0]), 32'd1);
    chk("F_rst_a4_key", 32'(akey_v[0]), 32'd0);
    chk("F_rst_kv", 32'(kv_v[0]), 32'd0);
    tick();
    rst[0] = 1'b0;
    tick();
    build(0, 0, 24'hFFFFFF, 1, 24'h000002, 0, 0);
    run(0, 0, 1'b0);
    chk("F_launches", 32'(n_launch[0]), 32'd3);
    chk("F_key", 32'(key_v[0]), 32'h000002);
    chk("F_kv", 32'(kv_v[0]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
